// File: rtl/dds_voice_bank_if.sv
// Frame-control and register-write bus of dds_voice_bank.
// The master drives ticks and register writes; the slave (the voice bank) returns the mixed sample.
interface dds_voice_bank_if #(
    parameter int OUT_W = 16
) ();
    logic             sample_tick;
    logic             wr_en;
    logic [3:0]       wr_voice;
    logic [1:0]       wr_field;
    logic [15:0]      wr_data;
    logic             busy;
    logic [OUT_W-1:0] sample_out;
    logic             sample_valid;
    logic             overrun;

    modport master (
        output sample_tick, wr_en, wr_voice, wr_field, wr_data,
        input  busy, sample_out, sample_valid, overrun
    );

    modport slave (
        input  sample_tick, wr_en, wr_voice, wr_field, wr_data,
        output busy, sample_out, sample_valid, overrun
    );
endinterface

// File: rtl/dds_voice_bank.sv
// Time-multiplexed DDS oscillator bank: one voice per cycle, summed and saturated once per frame.
// Optional macro DDS_SINE_LUT_EN adds a quarter-wave sine table for sel=3 (otherwise sel=3 is triangle).
module dds_voice_bank #(
    parameter int NUM_VOICES = 4,
    parameter int TUNE_W     = 16,
    parameter int WAVE_W     = 12,
    parameter int OUT_W      = 16
) (
    input  logic            clk,
    input  logic            rst,
    dds_voice_bank_if.slave bus
);
    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int ACC_W = WAVE_W + 4;
    localparam int SHIFT = OUT_W - WAVE_W;
    localparam int SAT_W = ACC_W + SHIFT;

    localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(NUM_VOICES - 1);
    localparam logic [WAVE_W-1:0]       WAVE_MID = {1'b1, {(WAVE_W-1){1'b0}}};
    localparam logic [OUT_W-1:0]        OUT_MID  = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic signed [SAT_W-1:0] SAT_MAX  = SAT_W'((longint'(1) << (OUT_W - 1)) - 1);
    localparam logic signed [SAT_W-1:0] SAT_MIN  = ~SAT_MAX;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        VOICE = 2'd1,
        MIX   = 2'd2
    } state_t;

`ifdef DDS_SINE_LUT_EN
    localparam int AMP_W = WAVE_W - 1;

    // Quarter-wave amplitudes at half-step sample points, Bhaskara rational approximation of sin.
    function automatic logic [256*AMP_W-1:0] build_sine_rom();
        logic [256*AMP_W-1:0] rom;
        longint u, prod, num, den, amp;
        rom = '0;
        for (int k = 0; k < 256; k++) begin
            u    = longint'(2 * k + 1);
            prod = u * (longint'(1024) - u);
            num  = longint'(16) * prod * ((longint'(1) << AMP_W) - longint'(1));
            den  = longint'(5 * 1024 * 1024) - longint'(4) * prod;
            amp  = (num + den / longint'(2)) / den;
            rom[k*AMP_W +: AMP_W] = AMP_W'(amp);
        end
        return rom;
    endfunction

    localparam logic [256*AMP_W-1:0] SINE_ROM = build_sine_rom();

    function automatic logic [WAVE_W-1:0] sine_wave(input logic [TUNE_W-1:0] ph);
        logic [7:0]       addr;
        logic [AMP_W-1:0] amp;
        addr = ph[TUNE_W-3 -: 8];
        if (ph[TUNE_W-2]) addr = ~addr;
        amp = SINE_ROM[int'(addr)*AMP_W +: AMP_W];
        if (ph[TUNE_W-1]) return ~{1'b1, amp};
        return {1'b1, amp};
    endfunction
`endif

    function automatic logic [WAVE_W-1:0] wave_of(input logic [TUNE_W-1:0] ph,
                                                  input logic [2:0]        sel,
                                                  input logic [WAVE_W-1:0] pw);
        logic [WAVE_W-1:0] p;
        logic [WAVE_W-1:0] tri_w;
        p     = ph[TUNE_W-1 -: WAVE_W];
        tri_w = ph[TUNE_W-2 -: WAVE_W];
        if (ph[TUNE_W-1]) tri_w = ~tri_w;
        case (sel)
            3'd0:    return p;
            3'd1:    return (p < pw) ? '1 : '0;
            3'd2:    return tri_w;
`ifdef DDS_SINE_LUT_EN
            3'd3:    return sine_wave(ph);
`else
            3'd3:    return tri_w;
`endif
            default: return WAVE_MID;
        endcase
    endfunction

    function automatic logic [OUT_W-1:0] mix_out(input logic signed [ACC_W-1:0] acc);
        logic signed [SAT_W-1:0] s;
        logic [OUT_W-1:0]        r;
        s = {acc, {SHIFT{1'b0}}};
        if (s > SAT_MAX)      r = SAT_MAX[OUT_W-1:0];
        else if (s < SAT_MIN) r = SAT_MIN[OUT_W-1:0];
        else                  r = s[OUT_W-1:0];
        return {~r[OUT_W-1], r[OUT_W-2:0]};
    endfunction

    state_t                  state_q;
    logic [IDX_W-1:0]        idx_q;
    logic signed [ACC_W-1:0] acc_q;
    logic                    busy_q;
    logic [OUT_W-1:0]        sample_out_q;
    logic                    sample_valid_q;
    logic                    overrun_q;

    logic [TUNE_W-1:0]       phase_q [NUM_VOICES];
    logic [TUNE_W-1:0]       tune_q  [NUM_VOICES];
    logic [WAVE_W-1:0]       pw_q    [NUM_VOICES];
    logic [2:0]              sel_q   [NUM_VOICES];
    logic [NUM_VOICES-1:0]   en_q;

    logic [TUNE_W-1:0]       vphase_d;
    logic [WAVE_W-1:0]       vwave;
    logic signed [WAVE_W:0]  vcontrib;
    logic signed [ACC_W-1:0] acc_d;
    logic                    wr_ok;
    logic                    voice_step;

    // Datapath for the voice selected by idx_q; uses pre-write register values.
    always_comb begin
        vphase_d = phase_q[idx_q] + tune_q[idx_q];
        vwave    = wave_of(vphase_d, sel_q[idx_q], pw_q[idx_q]);
        vcontrib = '0;
        if (en_q[idx_q]) vcontrib = $signed({1'b0, vwave}) - $signed({1'b0, WAVE_MID});
        acc_d    = acc_q + ACC_W'(vcontrib);
    end

    assign wr_ok      = bus.wr_en && (int'(bus.wr_voice) < NUM_VOICES) && (bus.wr_field != 2'd3);
    assign voice_step = (state_q == VOICE);

    // Phase clear is written after the accumulate so it takes priority on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                phase_q[v] <= '0;
                tune_q[v]  <= '0;
                pw_q[v]    <= '0;
                sel_q[v]   <= '0;
            end
            en_q <= '0;
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (voice_step && idx_q == IDX_W'(v) && en_q[v]) phase_q[v] <= vphase_d;
                if (wr_ok && bus.wr_voice == 4'(v)) begin
                    case (bus.wr_field)
                        2'd0: tune_q[v] <= TUNE_W'(bus.wr_data);
                        2'd1: begin
                            en_q[v]  <= bus.wr_data[3];
                            sel_q[v] <= bus.wr_data[2:0];
                            if (bus.wr_data[4]) phase_q[v] <= '0;
                        end
                        2'd2: pw_q[v] <= WAVE_W'(bus.wr_data);
                        default: ;
                    endcase
                end
            end
        end
    end

    // Frame sequencer; the mixed sample is registered on entry to MIX so it is visible during MIX.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            acc_q          <= '0;
            busy_q         <= 1'b0;
            sample_out_q   <= OUT_MID;
            sample_valid_q <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            sample_valid_q <= 1'b0;
            overrun_q      <= bus.sample_tick && busy_q;
            case (state_q)
                IDLE: begin
                    if (bus.sample_tick) begin
                        state_q <= VOICE;
                        idx_q   <= '0;
                        acc_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                VOICE: begin
                    acc_q <= acc_d;
                    if (idx_q == LAST_IDX) begin
                        state_q        <= MIX;
                        sample_out_q   <= mix_out(acc_d);
                        sample_valid_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                MIX: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy         = busy_q;
    assign bus.sample_out   = sample_out_q;
    assign bus.sample_valid = sample_valid_q;
    assign bus.overrun      = overrun_q;
endmodule

// File: tb/tb_dds_voice_bank.sv
// Bench for dds_voice_bank: directed vector table, corner sequences and a random run vs a reference model.
module tb_dds_voice_bank;
    localparam int NV = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    dds_voice_bank_if #(.OUT_W(16)) bus ();

    dds_voice_bank #(
        .NUM_VOICES(NV),
        .TUNE_W(16),
        .WAVE_W(12),
        .OUT_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model state: plain integers per voice.
    int m_ph [NV];
    int m_tune [NV];
    int m_pw [NV];
    int m_sel [NV];
    int m_en [NV];

    typedef struct {
        logic [15:0] tune;
        logic [15:0] ctrl;
        logic [15:0] pw;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic m_reset();
        for (int v = 0; v < NV; v++) begin
            m_ph[v] = 0; m_tune[v] = 0; m_pw[v] = 0; m_sel[v] = 0; m_en[v] = 0;
        end
    endtask

    task automatic m_write(input int v, input int f, input logic [15:0] d);
        if (v < NV && f != 3) begin
            case (f)
                0: m_tune[v] = int'(d);
                1: begin
                    m_en[v]  = int'(d[3]);
                    m_sel[v] = int'(d[2:0]);
                    if (d[4]) m_ph[v] = 0;
                end
                default: m_pw[v] = int'(d) % 4096;
            endcase
        end
    endtask

    function automatic int wave_ref(input int ph, input int s, input int pw);
        int p, t;
        p = ph / 16;
        t = (ph / 8) % 4096;
        if (ph >= 32768) t = 4095 - t;
        case (s)
            0:       return p;
            1:       return (p < pw) ? 4095 : 0;
            2, 3:    return t;
            default: return 2048;
        endcase
    endfunction

    task automatic m_frame(output logic [15:0] exp);
        int sum, s;
        sum = 0;
        for (int v = 0; v < NV; v++) begin
            if (m_en[v] != 0) begin
                m_ph[v] = (m_ph[v] + m_tune[v]) % 65536;
                sum += wave_ref(m_ph[v], m_sel[v], m_pw[v]) - 2048;
            end
        end
        s = sum * 16;
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        exp = 16'(s + 32768);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int v, input int f, input logic [15:0] d);
        bus.wr_en    = 1'b1;
        bus.wr_voice = 4'(v);
        bus.wr_field = 2'(f);
        bus.wr_data  = d;
        step();
        bus.wr_en    = 1'b0;
        m_write(v, f, d);
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        bus.sample_tick = 1'b1;
        bus.wr_en       = 1'b1;
        bus.wr_voice    = 4'd0;
        bus.wr_field    = 2'd1;
        bus.wr_data     = 16'h0008;
        step();
        step();
        chk("rst_busy", bus.busy, 0);
        chk("rst_valid", bus.sample_valid, 0);
        chk("rst_overrun", bus.overrun, 0);
        chk("rst_out", bus.sample_out, 16'h8000);
        rst             = 1'b0;
        bus.sample_tick = 1'b0;
        bus.wr_en       = 1'b0;
        step();
        chk("post_rst_busy", bus.busy, 0);
        m_reset();
    endtask

    // One frame: tick, optional in-frame tick at cycle tcyc and write at cycle wcyc (0 = none).
    task automatic do_frame(input string nm, input logic [15:0] exp, input int tcyc,
                            input int wcyc, input int wv, input int wf, input logic [15:0] wd);
        int          vcnt, vcyc, ocnt;
        logic [15:0] got;
        bit          busy_ok;
        vcnt = 0; vcyc = -1; ocnt = 0; got = 16'h0; busy_ok = 1'b1;
        bus.sample_tick = 1'b1;
        step();
        bus.sample_tick = 1'b0;
        for (int c = 1; c <= NV + 4; c++) begin
            if (bus.sample_valid) begin
                vcnt++;
                vcyc = c;
                got  = bus.sample_out;
            end
            if (bus.overrun) ocnt++;
            if (bus.busy !== 1'(c <= NV + 1)) busy_ok = 1'b0;
            bus.sample_tick = 1'(c == tcyc);
            if (c == wcyc) begin
                bus.wr_en    = 1'b1;
                bus.wr_voice = 4'(wv);
                bus.wr_field = 2'(wf);
                bus.wr_data  = wd;
            end else begin
                bus.wr_en = 1'b0;
            end
            step();
        end
        bus.sample_tick = 1'b0;
        bus.wr_en       = 1'b0;
        chk({nm, "_valid_cnt"}, vcnt, 1);
        chk({nm, "_latency"}, vcyc, NV + 1);
        chk({nm, "_sample"}, got, exp);
        chk({nm, "_busy"}, busy_ok, 1);
        chk({nm, "_overrun"}, ocnt, (tcyc > 0) ? 1 : 0);
    endtask

    initial begin
        logic [15:0] exp;
        int          vcnt;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.sample_tick = 1'b0;
        bus.wr_en       = 1'b0;
        bus.wr_voice    = 4'd0;
        bus.wr_field    = 2'd0;
        bus.wr_data     = 16'h0;

        tbl[0]  = '{16'h0400, 16'h0018, 16'h0000, 16'h0400};
        tbl[1]  = '{16'h8000, 16'h0018, 16'h0000, 16'h8000};
        tbl[2]  = '{16'hFFF0, 16'h0018, 16'h0000, 16'hFFF0};
        tbl[3]  = '{16'h0000, 16'h0018, 16'h0000, 16'h0000};
        tbl[4]  = '{16'h1000, 16'h0019, 16'h0800, 16'hFFF0};
        tbl[5]  = '{16'h9000, 16'h0019, 16'h0800, 16'h0000};
        tbl[6]  = '{16'h4000, 16'h001A, 16'h0000, 16'h8000};
        tbl[7]  = '{16'h2000, 16'h001A, 16'h0000, 16'h4000};
        tbl[8]  = '{16'hC000, 16'h001A, 16'h0000, 16'h7FF0};
        tbl[9]  = '{16'h1234, 16'h001D, 16'h0000, 16'h8000};
        tbl[10] = '{16'h4000, 16'h0010, 16'h0000, 16'h8000};
        tbl[11] = '{16'h7000, 16'h0019, 16'hF800, 16'hFFF0};

        do_reset();
        do_frame("idle_after_rst", 16'h8000, 0, 0, 0, 0, 16'h0);

        for (int i = 0; i < 12; i++) begin
            wr(0, 0, tbl[i].tune);
            wr(0, 2, tbl[i].pw);
            wr(0, 1, tbl[i].ctrl);
            do_frame($sformatf("vec%0d", i), tbl[i].exp, 0, 0, 0, 0, 16'h0);
        end

        // Two saw voices at the top and bottom of the range drive the mix into saturation.
        do_reset();
        wr(0, 0, 16'hFFF0); wr(1, 0, 16'hFFF0);
        wr(0, 1, 16'h0018); wr(1, 1, 16'h0018);
        do_frame("sat_hi", 16'hFFFF, 0, 0, 0, 0, 16'h0);
        wr(0, 0, 16'h0000); wr(1, 0, 16'h0000);
        wr(0, 1, 16'h0018); wr(1, 1, 16'h0018);
        do_frame("sat_lo", 16'h0000, 0, 0, 0, 0, 16'h0);
        repeat (5) step();
        chk("hold_out", bus.sample_out, 16'h0000);

        do_reset();
        wr(0, 2, 16'h0800); wr(0, 0, 16'h1000); wr(0, 1, 16'h0019);
        for (int k = 1; k <= 16; k++) begin
            exp = ((((k * 16'h1000) % 65536) / 16) < 16'h800) ? 16'hFFF0 : 16'h0000;
            do_frame($sformatf("sq%0d", k), exp, 0, 0, 0, 0, 16'h0);
        end

        do_reset();
        wr(0, 0, 16'h0400); wr(0, 1, 16'h0018);
        do_frame("ovr", 16'h0400, 2, 0, 0, 0, 16'h0);

        do_reset();
        wr(2, 0, 16'h1000); wr(2, 1, 16'h0018);
        do_frame("clr_f1", 16'h1000, 0, 0, 0, 0, 16'h0);
        do_frame("clr_f2", 16'h2000, 0, 3, 2, 1, 16'h0018);
        do_frame("clr_f3", 16'h1000, 0, 0, 0, 0, 16'h0);
        wr(6, 1, 16'h0010);
        wr(5, 1, 16'h0008);
        wr(2, 3, 16'h0010);
        do_frame("bad_wr", 16'h2000, 0, 0, 0, 0, 16'h0);

        // Reset during voice index 2 aborts the frame.
        do_reset();
        wr(0, 0, 16'h0400); wr(0, 1, 16'h0018);
        do_frame("pre_rst", 16'h0400, 0, 0, 0, 0, 16'h0);
        bus.sample_tick = 1'b1;
        step();
        bus.sample_tick = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_valid", bus.sample_valid, 0);
        chk("midrst_out", bus.sample_out, 16'h8000);
        rst = 1'b0;
        m_reset();
        vcnt = 0;
        for (int c = 0; c < 8; c++) begin
            if (bus.sample_valid) vcnt++;
            step();
        end
        chk("midrst_no_valid", vcnt, 0);
        do_frame("midrst_cleared", 16'h8000, 0, 0, 0, 0, 16'h0);

        do_reset();
        wr(0, 0, 16'h4000); wr(0, 1, 16'h001B);
`ifdef DDS_SINE_LUT_EN
        do_frame("sel3_peak", 16'hFFF0, 0, 0, 0, 0, 16'h0);
`else
        do_frame("sel3_peak", 16'h8000, 0, 0, 0, 0, 16'h0);
`endif
        wr(0, 0, 16'hC000); wr(0, 1, 16'h001B);
`ifdef DDS_SINE_LUT_EN
        do_frame("sel3_trough", 16'h0000, 0, 0, 0, 0, 16'h0);
`else
        do_frame("sel3_trough", 16'h7FF0, 0, 0, 0, 0, 16'h0);
`endif

        do_reset();
        for (int r = 0; r < 40; r++) begin
            int          nw, v, f;
            logic [15:0] d;
            nw = int'($urandom_range(1, 4));
            for (int w = 0; w < nw; w++) begin
                v = int'($urandom_range(0, 5));
                f = int'($urandom_range(0, 3));
                d = 16'($urandom);
`ifdef DDS_SINE_LUT_EN
                if (f == 1 && d[2:0] == 3'd3) d[2:0] = 3'd2;
`endif
                wr(v, f, d);
            end
            m_frame(exp);
            do_frame($sformatf("rand%0d", r), exp, 0, 0, 0, 0, 16'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
